seg7_reader: RTL and testbench

Receiving end of the 7-segment display interface. It samples a time-multiplexed 4-digit segment bus (segments A–G plus a one-hot digit select) and converts each stable segment pattern back to BCD. It assembles a 4-digit frame and hands it downstream over a valid/ready handshake. It sits between a display-bus monitor or loopback and any logic that needs the displayed value as numbers.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_reader.sv | 203 ++++++++++++++++++++
 tb/tb_seg7_reader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display receive path.
//   seg_t        : segment vector {A,B,C,D,E,F,G}, 1 = segment lit
//   SEG_0..SEG_9 : legal digit patterns
//   SEG_BLANK    : all segments off
//   BLANK_NIBBLE : nibble reported for a blank digit
//   ERR_NIBBLE   : nibble reported for an illegal pattern
//   is_onehot4() : true when exactly one of four select bits is set
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam logic [3:0] ERR_NIBBLE   = 4'hE;

  localparam int unsigned NUM_DIGITS = 4;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational segment-pattern to BCD decoder.
//   seg    in  7  segment vector {A,B,C,D,E,F,G}
//   nibble out 4  BCD digit, BLANK_NIBBLE for blank, ERR_NIBBLE for illegal
//   err    out 1  pattern is neither a digit 0-9 nor blank
//   blank  out 1  all segments off
module seg7_decode
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       err,
  output logic       blank
);

  always_comb begin
    nibble = ERR_NIBBLE;
    err    = 1'b1;
    blank  = 1'b0;
    case (seg)
      SEG_0: begin nibble = 4'd0; err = 1'b0; end
      SEG_1: begin nibble = 4'd1; err = 1'b0; end
      SEG_2: begin nibble = 4'd2; err = 1'b0; end
      SEG_3: begin nibble = 4'd3; err = 1'b0; end
      SEG_4: begin nibble = 4'd4; err = 1'b0; end
      SEG_5: begin nibble = 4'd5; err = 1'b0; end
      SEG_6: begin nibble = 4'd6; err = 1'b0; end
      SEG_7: begin nibble = 4'd7; err = 1'b0; end
      SEG_8: begin nibble = 4'd8; err = 1'b0; end
      SEG_9: begin nibble = 4'd9; err = 1'b0; end
      SEG_BLANK: begin
        nibble = BLANK_NIBBLE;
        err    = 1'b0;
        blank  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: samples a multiplexed 4-digit 7-segment bus, captures each
// digit once its pattern has been stable for STABLE_CNT samples, assembles a
// 4-digit frame and presents it downstream over valid/ready.
//   clk, reset        clock, synchronous active-high reset
//   A..G              segment lines, 1 = lit
//   dig_sel[3:0]      one-hot active digit, bit 3 = most significant
//   out_bcd[15:0]     frame, [15:12] = digit 3
//   out_err[3:0]      per-digit illegal-pattern flag
//   out_blank[3:0]    per-digit blank flag
//   out_valid         frame available
//   out_ready         downstream accepts the frame
//   overrun           sticky: complete working frame modified while output full
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        E,
  input  logic        F,
  input  logic        G,
  input  logic [3:0]  dig_sel,
  output logic [15:0] out_bcd,
  output logic [3:0]  out_err,
  output logic [3:0]  out_blank,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [0:0] ST_SCAN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_FULL   = 1'b1;

  localparam logic [3:0] CNT_TARGET = 4'(STABLE_CNT);

  // ---------------------------------------------------------------------------
  // Input stage: current registered sample plus the one before it.
  // ---------------------------------------------------------------------------
  seg_t       seg_in;
  seg_t       seg_r, seg_p;
  logic [3:0] sel_r, sel_p;

  assign seg_in = {A, B, C, D, E, F, G};

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= SEG_BLANK;
      sel_r <= 4'b0000;
      seg_p <= SEG_BLANK;
      sel_p <= 4'b0000;
    end else begin
      seg_r <= seg_in;
      sel_r <= dig_sel;
      seg_p <= seg_r;
      sel_p <= sel_r;
    end
  end

  logic sel_onehot;
  logic same_sample;

  assign sel_onehot  = is_onehot4(sel_r);
  assign same_sample = (seg_r == seg_p) && (sel_r == sel_p);

  // ---------------------------------------------------------------------------
  // Stability FSM. cnt holds the length of the current run of identical
  // one-hot samples ending at seg_p; a capture fires when the sample in
  // seg_r extends a run that already reached STABLE_CNT.
  // ---------------------------------------------------------------------------
  logic [0:0] stab_q, stab_d;
  logic [3:0] cnt_q, cnt_d;
  logic       capture;

  always_comb begin
    stab_d  = stab_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!sel_onehot) begin
      cnt_d  = 4'd0;
      stab_d = ST_SCAN;
    end else if (!same_sample) begin
      cnt_d  = 4'd1;
      stab_d = ST_SCAN;
    end else if (stab_q == ST_SCAN) begin
      if (cnt_q == CNT_TARGET) begin
        capture = 1'b1;
        stab_d  = ST_LOCKED;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stab_q <= ST_SCAN;
      cnt_q  <= 4'd0;
    end else begin
      stab_q <= stab_d;
      cnt_q  <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the registered pattern.
  // ---------------------------------------------------------------------------
  logic [3:0] dec_nibble;
  logic       dec_err;
  logic       dec_blank;

  seg7_decode u_decode (
    .seg    (seg_r),
    .nibble (dec_nibble),
    .err    (dec_err),
    .blank  (dec_blank)
  );

  // ---------------------------------------------------------------------------
  // Working frame and output FSM.
  // ---------------------------------------------------------------------------
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;
  logic [3:0]  frame_blank;
  logic [3:0]  seen_q, seen_d;
  logic [0:0]  out_st_q, out_st_d;
  logic        overrun_q, overrun_d;
  logic        complete;
  logic        handshake;
  logic        take;

  assign complete  = &seen_q;
  assign handshake = (out_st_q == ST_FULL) && out_ready;
  // A transfer always moves the pre-edge frame; a same-edge capture lands in
  // the freshly cleared frame and belongs to the next transfer.
  assign take      = complete && ((out_st_q == ST_EMPTY) || handshake);

  always_comb begin
    seen_d = take ? 4'b0000 : seen_q;
    if (capture) begin
      seen_d = seen_d | sel_r;
    end
  end

  always_comb begin
    out_st_d = out_st_q;
    if (take) begin
      out_st_d = ST_FULL;
    end else if (handshake) begin
      out_st_d = ST_EMPTY;
    end
  end

  // Overwriting a complete frame that cannot drain this edge loses data.
  assign overrun_d = overrun_q |
                     (capture && complete && (out_st_q == ST_FULL) && !out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_bcd   <= 16'h0000;
      frame_err   <= 4'b0000;
      frame_blank <= 4'b0000;
      seen_q      <= 4'b0000;
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_r[i]) begin
          frame_bcd[4*i +: 4] <= dec_nibble;
          frame_err[i]        <= dec_err;
          frame_blank[i]      <= dec_blank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_st_q  <= ST_EMPTY;
      overrun_q <= 1'b0;
      out_bcd   <= 16'h0000;
      out_err   <= 4'b0000;
      out_blank <= 4'b0000;
    end else begin
      out_st_q  <= out_st_d;
      overrun_q <= overrun_d;
      if (take) begin
        out_bcd   <= frame_bcd;
        out_err   <= frame_err;
        out_blank <= frame_blank;
      end
    end
  end

  assign out_valid = (out_st_q == ST_FULL);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed scenarios plus randomized bus traffic for
// seg7_reader, checked against a run-length/frame reference model through a
// scoreboard queue of expected frames.
module tb_seg7_reader;

  localparam int unsigned S = 3;
  localparam logic [6:0] CODES [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
    logic [3:0]  blank;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_drv;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;
  logic [3:0]  out_blank;
  logic        out_valid;
  logic        overrun;

  seg7_reader #(.STABLE_CNT(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (seg_drv[6]),
    .B         (seg_drv[5]),
    .C         (seg_drv[4]),
    .D         (seg_drv[3]),
    .E         (seg_drv[2]),
    .F         (seg_drv[1]),
    .G         (seg_drv[0]),
    .dig_sel   (dig_sel),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_blank (out_blank),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state.
  frame_t      exp_q[$];
  int          run_len = 0;
  logic        prev_ok = 1'b0;
  logic [6:0]  prev_seg = '0;
  logic [3:0]  prev_sel = '0;
  logic [15:0] w_bcd = '0;
  logic [3:0]  w_err = '0;
  logic [3:0]  w_blank = '0;
  logic [3:0]  w_seen = '0;
  logic        m_full = 1'b0;
  logic        m_overrun = 1'b0;
  logic        mon_en = 1'b0;
  bit          rnd_ready = 1'b0;
  int          rdy_pct = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic ref_decode(input logic [6:0] s, output logic [3:0] n, output logic e,
                            output logic b);
    n = 4'hE;
    e = 1'b1;
    b = 1'b0;
    if (s == 7'h00) begin
      n = 4'hF;
      e = 1'b0;
      b = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      if (CODES[k] == s) begin
        n = 4'(k);
        e = 1'b0;
      end
    end
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  // A run of S+1 identical one-hot samples is captured on the following edge.
  task automatic model_edge();
    logic       cap, hs, complete, oh, e, b;
    logic [3:0] n;
    int         idx;
    if (reset) begin
      run_len   = 0;
      prev_ok   = 1'b0;
      w_bcd     = '0;
      w_err     = '0;
      w_blank   = '0;
      w_seen    = '0;
      m_full    = 1'b0;
      m_overrun = 1'b0;
      exp_q.delete();
    end else begin
      cap      = (run_len == S + 1);
      hs       = m_full && out_ready;
      complete = (w_seen == 4'hF);
      if (cap && complete && m_full && !hs) m_overrun = 1'b1;
      if (complete && (!m_full || hs)) begin
        frame_t f;
        f.bcd   = w_bcd;
        f.err   = w_err;
        f.blank = w_blank;
        exp_q.push_back(f);
        m_full = 1'b1;
        w_seen = '0;
      end else if (hs) begin
        m_full = 1'b0;
      end
      if (cap) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (prev_sel[k]) idx = k;
        ref_decode(prev_seg, n, e, b);
        w_bcd[idx*4 +: 4] = n;
        w_err[idx]        = e;
        w_blank[idx]      = b;
        w_seen[idx]       = 1'b1;
      end
      oh = ($countones(dig_sel) == 1);
      if (oh && prev_ok && seg_drv == prev_seg && dig_sel == prev_sel) run_len++;
      else run_len = oh ? 1 : 0;
      prev_seg = seg_drv;
      prev_sel = dig_sel;
      prev_ok  = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] s, input int n);
    dig_sel = sel;
    seg_drv = s;
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) out_ready = ($urandom_range(99) < rdy_pct);
      tick();
    end
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Monitor: checks handshake-visible state and pops the scoreboard on accept.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("valid", 32'(out_valid), 32'(m_full));
        check("overrun", 32'(overrun), 32'(m_overrun));
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("frame_pending", 32'(exp_q.size()), 32'd1);
          end else begin
            f = exp_q.pop_front();
            check("frame_bcd", 32'(out_bcd), 32'(f.bcd));
            check("frame_err", 32'(out_err), 32'(f.err));
            check("frame_blank", 32'(out_blank), 32'(f.blank));
          end
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    seg_drv   = '0;
    dig_sel   = '0;
    out_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_bcd", 32'(out_bcd), 32'h0);
    check("rst_err", 32'(out_err), 32'h0);
    check("rst_blank", 32'(out_blank), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Basic frame 3210; valid one edge after the completing capture.
    hold(4'b1000, 7'h79, 4);
    hold(4'b0100, 7'h6D, 4);
    hold(4'b0010, 7'h30, 4);
    hold(4'b0001, 7'h7E, 4);
    hold(4'b0000, 7'h00, 1);
    check("f1_valid_early", 32'(out_valid), 32'h0);
    hold(4'b0000, 7'h00, 1);
    check("f1_valid", 32'(out_valid), 32'h1);
    check("f1_bcd", 32'(out_bcd), 32'h3210);
    check("f1_err", 32'(out_err), 32'h0);
    pulse_ready();

    // Too-short hold must not capture.
    hold(4'b0001, 7'h7F, 2);
    hold(4'b0000, 7'h00, 6);
    check("short_no_frame", 32'(out_valid), 32'h0);

    // Illegal pattern and blank digit.
    hold(4'b0010, 7'h01, 4);
    hold(4'b0100, 7'h00, 4);
    hold(4'b1000, 7'h79, 4);
    hold(4'b0001, 7'h7E, 4);
    hold(4'b0000, 7'h00, 2);
    check("eb_bcd", 32'(out_bcd), 32'h3FE0);
    check("eb_err", 32'(out_err), 32'h2);
    check("eb_blank", 32'(out_blank), 32'h4);
    pulse_ready();

    // Two frames with ready low, then a recapture into the complete one.
    hold(4'b1000, 7'h33, 4);
    hold(4'b0100, 7'h5B, 4);
    hold(4'b0010, 7'h5F, 4);
    hold(4'b0001, 7'h70, 4);
    hold(4'b1000, 7'h7F, 4);
    hold(4'b0100, 7'h7B, 4);
    hold(4'b0010, 7'h7E, 4);
    hold(4'b0001, 7'h30, 4);
    hold(4'b0001, 7'h5F, 4);
    hold(4'b0000, 7'h00, 2);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_hold_bcd", 32'(out_bcd), 32'h4567);
    pulse_ready();
    check("ovr_next_valid", 32'(out_valid), 32'h1);
    check("ovr_next_bcd", 32'(out_bcd), 32'h8906);

    // Non-one-hot selects and a glitch while locked.
    hold(4'b0011, 7'h79, 10);
    hold(4'b0000, 7'h79, 10);
    hold(4'b0100, 7'h6D, 6);
    hold(4'b0100, 7'h7F, 1);
    hold(4'b0100, 7'h6D, 2);
    hold(4'b0000, 7'h00, 2);

    // Reset with output full and three digits seen.
    hold(4'b1000, 7'h79, 4);
    hold(4'b0001, 7'h7E, 4);
    hold(4'b0000, 7'h00, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_bcd", 32'(out_bcd), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_err", 32'(out_err), 32'h0);
    hold(4'b1000, 7'h30, 4);
    hold(4'b0100, 7'h30, 4);
    hold(4'b0010, 7'h30, 4);
    hold(4'b0000, 7'h00, 6);
    check("post_rst_partial", 32'(out_valid), 32'h0);
    hold(4'b0001, 7'h7B, 4);
    hold(4'b0000, 7'h00, 2);
    check("post_rst_bcd", 32'(out_bcd), 32'h1119);
    pulse_ready();

    // Randomized traffic.
    rnd_ready = 1'b1;
    for (int it = 0; it < 600; it++) begin
      logic [3:0] sel;
      logic [6:0] s;
      int         r;
      if ($urandom_range(59) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      r = $urandom_range(99);
      if (r < 80) sel = 4'b0001 << $urandom_range(3);
      else sel = 4'($urandom_range(15));
      r = $urandom_range(99);
      if (r < 70) s = CODES[$urandom_range(9)];
      else if (r < 80) s = 7'h00;
      else s = 7'($urandom_range(127));
      rdy_pct = $urandom_range(100);
      hold(sel, s, $urandom_range(6, 1));
    end

    // Drain everything still in flight.
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    hold(4'b0000, 7'h00, 12);
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    check("drain_valid", 32'(out_valid), 32'h0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
